ddr_mem_burst: RTL and testbench
================================

DDR_MEM_BURST -- requirements
Module: ddr_mem_burst

Interface
REQ-001 SHALL have parameter DATA_W, default 8: data bits per word (8, 16 or 32).
REQ-002 SHALL have parameter DEPTH, default 65536: words stored, power of two.
REQ-003 SHALL have parameter READ_LATENCY, default 3: pipeline stages from beat issue to response FIFO write, at least 1.
REQ-004 SHALL have parameter LEN_W, default 4: burst length field width (1 to 2^LEN_W beats).
REQ-005 SHALL have parameter RESP_DEPTH, default 8: response FIFO entries, power of two, at least READ_LATENCY+1.
REQ-006 SHALL have port clk, input, 1: single clock; all logic is rising-edge.
REQ-007 SHALL have port rst_n, input, 1: synchronous active-low reset.
REQ-008 SHALL have port rd_req_valid, input, 1: read burst request.
REQ-009 SHALL have port rd_req_ready, output, 1: read request accepted when valid and ready are both high.
REQ-010 SHALL have port rd_req_addr, input, 32: start word address.
REQ-011 SHALL have port rd_req_len, input, LEN_W: beats minus 1.
REQ-012 SHALL have port rd_resp_valid, output, 1: response beat available.
REQ-013 SHALL have port rd_resp_ready, input, 1: consumer accepts beat.
REQ-014 SHALL have port rd_resp_data, output, DATA_W: beat data.
REQ-015 SHALL have port rd_resp_last, output, 1: final beat of burst.
REQ-016 SHALL have port rd_resp_err, output, 1: beat address out of range.
REQ-017 SHALL have port wr_valid, input, 1: single-word write.
REQ-018 SHALL have port wr_addr, input, 32: write word address.
REQ-019 SHALL have port wr_data, input, DATA_W: write data.
REQ-020 SHALL have port wr_strb, input, DATA_W/8: byte enables.

Function
REQ-021 SHALL run a read FSM with states IDLE and BURST; IDLE->BURST on accept; BURST->IDLE after issuing the last beat.
REQ-022 SHALL hold rd_req_ready high only in IDLE; back-to-back bursts SHALL have one idle cycle between them.
REQ-023 SHALL issue one beat per cycle in BURST, at addresses start, start+1, and so on, wrapping modulo DEPTH.
REQ-024 SHALL stall beat issue while the sum of FIFO occupancy and in-flight beats equals RESP_DEPTH, so the FIFO never overflows.
REQ-025 SHALL write a beat issued at cycle N into the FIFO at cycle N+READ_LATENCY; with an empty FIFO, rd_resp_valid SHALL rise at that cycle.
REQ-026 SHALL present FIFO head beats in order; a beat pops when rd_resp_valid and rd_resp_ready are both high; while ready is low, data, last and err SHALL hold stable.
REQ-027 SHALL write only the bytes whose wr_strb bit is high; the write port SHALL always accept, with no stall.
REQ-028 SHALL give a beat issued in the same cycle as a write to the same address the old data; beats issued later see the new data.
REQ-029 SHALL keep the FIFO free of corruption under a simultaneous FIFO push and pop, whether the FIFO is full or empty.

Reset
REQ-030 SHALL, while rst_n is low at a clock edge, force: FSM to IDLE; pipeline valids, FIFO pointers and counters to 0; rd_resp_valid, rd_resp_last and rd_resp_err to 0; rd_resp_data to 0.
REQ-031 SHALL discard any burst or in-flight beats on reset mid-operation; no beat is delivered afterwards.
REQ-032 SHALL not reset memory contents.

Configuration
REQ-033 SHALL, when DDR_MEM_ADDR_CHECK_EN is defined, treat a beat or write with address >= DEPTH as follows: the write is dropped, the beat returns data 0 with rd_resp_err=1, and the burst does not wrap.
REQ-034 SHALL, when DDR_MEM_ADDR_CHECK_EN is undefined, index addresses modulo DEPTH and tie rd_resp_err to 0.

Verification
REQ-035 SHALL cover: write 0xA5 to addr 0x10; read len=0 at addr 0x10 with ready held high -> one beat 0xA5, last=1, valid at issue+READ_LATENCY.
REQ-036 SHALL cover: DATA_W=32, word 0x11223344 at addr 4, then a write of 0xFFFFFFFF with strb=4'b0101 -> read returns 0x11FF33FF.
REQ-037 SHALL cover: burst len=7 from addr DEPTH-2 (check undefined) -> data from DEPTH-2, DEPTH-1, 0 through 5, last only on beat 8.
REQ-038 SHALL cover: len=15 burst with rd_resp_ready low for 20 cycles -> issue stalls with the FIFO at RESP_DEPTH, no loss, all 16 beats in order after release.
REQ-039 SHALL cover: rst_n low for 1 cycle mid-burst -> valid=0 next cycle, no stale beats, rd_req_ready=1.
REQ-040 SHALL cover: DDR_MEM_ADDR_CHECK_EN defined, read at DEPTH+3 -> data 0 with err=1; write there leaves memory unchanged.

Source files
------------

// File: rtl/ddr_mem_burst.sv
// rtl/ddr_mem_burst.sv - burst-read word memory with latency pipeline and response FIFO (optional macro DDR_MEM_ADDR_CHECK_EN)
module ddr_mem_burst #(
    parameter int DATA_W       = 8,
    parameter int DEPTH        = 65536,
    parameter int READ_LATENCY = 3,
    parameter int LEN_W        = 4,
    parameter int RESP_DEPTH   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rd_req_valid,
    output logic                rd_req_ready,
    input  logic [31:0]         rd_req_addr,
    input  logic [LEN_W-1:0]    rd_req_len,
    output logic                rd_resp_valid,
    input  logic                rd_resp_ready,
    output logic [DATA_W-1:0]   rd_resp_data,
    output logic                rd_resp_last,
    output logic                rd_resp_err,
    input  logic                wr_valid,
    input  logic [31:0]         wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_strb
);
    localparam int AW     = $clog2(DEPTH);
    localparam int PW     = $clog2(RESP_DEPTH);
    localparam int CW     = PW + 1;
    localparam int SW     = DATA_W / 8;
    localparam int BEAT_W = DATA_W + 2;

    typedef enum logic [0:0] {IDLE, BURST} state_t;

    state_t              state, state_nxt;
    logic [31:0]         beat_addr;
    logic [LEN_W-1:0]    beats_left;
    logic [CW-1:0]       pending;
    logic                issue;
    logic                pop;
    logic                push;
    logic [BEAT_W-1:0]   push_beat;
    logic [BEAT_W-1:0]   issue_beat;
    logic [DATA_W-1:0]   beat_data;
    logic                beat_err;
    logic                wr_ok;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [BEAT_W-1:0]   fifo [RESP_DEPTH];
    logic [PW-1:0]       wr_ptr, rd_ptr;
    logic [CW-1:0]       count;

`ifdef DDR_MEM_ADDR_CHECK_EN
    localparam logic [31:0] DEPTH_L = 32'(DEPTH);
    // Out-of-range beats return zero with an error flag; out-of-range writes are dropped.
    assign beat_err  = (beat_addr >= DEPTH_L);
    assign beat_data = beat_err ? '0 : mem[beat_addr[AW-1:0]];
    assign wr_ok     = (wr_addr < DEPTH_L);
`else
    // Only the low address bits index the array, which gives modulo-DEPTH wrapping.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{wr_addr[31:AW], beat_addr[31:AW]};
    assign beat_err  = 1'b0;
    assign beat_data = mem[beat_addr[AW-1:0]];
    assign wr_ok     = 1'b1;
`endif

    assign issue_beat = {beat_err, (beats_left == '0), beat_data};

    // Read FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state, request handshake and beat issue; issue holds off while every FIFO slot is spoken for.
    always_comb begin
        state_nxt    = state;
        rd_req_ready = 1'b0;
        issue        = 1'b0;
        case (state)
            IDLE: begin
                rd_req_ready = 1'b1;
                if (rd_req_valid) state_nxt = BURST;
            end
            BURST: begin
                if (pending != CW'(RESP_DEPTH)) begin
                    issue = 1'b1;
                    if (beats_left == '0) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Burst address and remaining-beat tracking.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_addr  <= '0;
            beats_left <= '0;
        end else if (rd_req_valid && rd_req_ready) begin
            beat_addr  <= rd_req_addr;
            beats_left <= rd_req_len;
        end else if (issue) begin
            beat_addr  <= beat_addr + 32'd1;
            beats_left <= beats_left - LEN_W'(1);
        end
    end

    // Beats issued but not yet popped; bounds pipeline plus FIFO occupancy.
    always_ff @(posedge clk) begin
        if (!rst_n) pending <= '0;
        else if (issue && !pop) pending <= pending + CW'(1);
        else if (!issue && pop) pending <= pending - CW'(1);
    end

    // Byte-masked write port; the array is never reset. A same-cycle read sees the old word.
    always_ff @(posedge clk) begin
        if (wr_valid && wr_ok) begin
            for (int b = 0; b < SW; b++) begin
                if (wr_strb[b]) mem[wr_addr[AW-1:0]][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
        end
    end

    generate
        if (READ_LATENCY == 1) begin : g_no_pipe
            assign push      = issue;
            assign push_beat = issue_beat;
        end else begin : g_pipe
            logic              pv [READ_LATENCY-1];
            logic [BEAT_W-1:0] pd [READ_LATENCY-1];
            // Delay line so a beat reaches the FIFO READ_LATENCY cycles after issue.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int i = 0; i < READ_LATENCY-1; i++) pv[i] <= 1'b0;
                end else begin
                    pv[0] <= issue;
                    for (int i = 1; i < READ_LATENCY-1; i++) pv[i] <= pv[i-1];
                end
                pd[0] <= issue_beat;
                for (int i = 1; i < READ_LATENCY-1; i++) pd[i] <= pd[i-1];
            end
            assign push      = pv[READ_LATENCY-2];
            assign push_beat = pd[READ_LATENCY-2];
        end
    endgenerate

    assign pop = (count != '0) && rd_resp_ready;

    // Response FIFO storage.
    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr] <= push_beat;
    end

    // Response FIFO pointers and occupancy; push and pop may coincide.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (!push && pop) count <= count - CW'(1);
        end
    end

    assign rd_resp_valid = (count != '0);
    assign {rd_resp_err, rd_resp_last, rd_resp_data} = rd_resp_valid ? fifo[rd_ptr] : '0;
endmodule

// File: tb/tb_ddr_mem_burst.sv
// tb/tb_ddr_mem_burst.sv - randomized self-checking bench for ddr_mem_burst against a word-array model
module tb_ddr_mem_burst;
    localparam int DW    = 32;
    localparam int DEPTH = 64;
    localparam int RL    = 3;
    localparam int LW    = 4;
    localparam int RD    = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rd_req_valid = 1'b0;
    logic          rd_req_ready;
    logic [31:0]   rd_req_addr = '0;
    logic [LW-1:0] rd_req_len = '0;
    logic          rd_resp_valid;
    logic          rd_resp_ready = 1'b0;
    logic [DW-1:0] rd_resp_data;
    logic          rd_resp_last;
    logic          rd_resp_err;
    logic          wr_valid = 1'b0;
    logic [31:0]   wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [3:0]    wr_strb = '0;

    int errors = 0;
    int checks = 0;
    logic [DW-1:0] model [DEPTH];

    always #5 clk = ~clk;

    ddr_mem_burst #(
        .DATA_W(DW), .DEPTH(DEPTH), .READ_LATENCY(RL), .LEN_W(LW), .RESP_DEPTH(RD)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
        .rd_req_addr(rd_req_addr), .rd_req_len(rd_req_len),
        .rd_resp_valid(rd_resp_valid), .rd_resp_ready(rd_resp_ready),
        .rd_resp_data(rd_resp_data), .rd_resp_last(rd_resp_last), .rd_resp_err(rd_resp_err),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb)
    );

    task automatic do_write(input logic [31:0] a, input logic [DW-1:0] d, input logic [3:0] s);
        int idx;
        @(posedge clk); #1;
        wr_valid = 1'b1; wr_addr = a; wr_data = d; wr_strb = s;
        @(posedge clk); #1;
        wr_valid = 1'b0;
`ifdef DDR_MEM_ADDR_CHECK_EN
        if (a >= 32'(DEPTH)) return;
`endif
        idx = int'(a % 32'(DEPTH));
        for (int b = 0; b < 4; b++) if (s[b]) model[idx][b*8 +: 8] = d[b*8 +: 8];
    endtask

    // mode 0: ready held high, 1: random ready, 2: ready low for 20 cycles then high
    task automatic do_read(input logic [31:0] a, input logic [LW-1:0] len, input int mode,
                           output int first_k, output logic [DW-1:0] first_d);
        logic [DW-1:0] qd[$];
        bit ql[$];
        bit qe[$];
        logic [31:0] ba;
        int k;
        int beat;
        bit popped_any;
        for (int i = 0; i <= int'(len); i++) begin
            ba = a + 32'(i);
`ifdef DDR_MEM_ADDR_CHECK_EN
            if (ba >= 32'(DEPTH)) begin qd.push_back('0); qe.push_back(1'b1); end
            else begin qd.push_back(model[ba]); qe.push_back(1'b0); end
`else
            qd.push_back(model[ba % 32'(DEPTH)]); qe.push_back(1'b0);
`endif
            ql.push_back(i == int'(len));
        end
        first_k = -1; first_d = '0; popped_any = 0; beat = 0;
        @(posedge clk); #1;
        rd_req_valid = 1'b1; rd_req_addr = a; rd_req_len = len; rd_resp_ready = (mode == 0);
        @(negedge clk);
        checks++;
        if (rd_req_ready !== 1'b1) begin errors++; $display("FAIL req_ready: got %b want 1", rd_req_ready); end
        k = 0;
        while (qd.size() > 0 && k < 400) begin
            @(posedge clk); #1;
            k++;
            rd_req_valid = 1'b0;
            case (mode)
                0:       rd_resp_ready = 1'b1;
                1:       rd_resp_ready = 1'($urandom_range(0, 1));
                default: rd_resp_ready = (k > 20);
            endcase
            @(negedge clk);
            if (mode == 2 && k == 20) begin
                checks++;
                if (rd_resp_valid !== 1'b1 || rd_resp_data !== qd[0] || rd_req_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_hold: valid=%b data=%h req_ready=%b want 1 %h 0",
                             rd_resp_valid, rd_resp_data, rd_req_ready, qd[0]);
                end
            end
            if (rd_resp_valid === 1'b1) begin
                if (first_k < 0) first_k = k;
                if (rd_resp_ready) begin
                    checks++;
                    if (rd_resp_data !== qd[0] || rd_resp_last !== ql[0] || rd_resp_err !== qe[0]) begin
                        errors++;
                        $display("FAIL beat %0d @%h: data=%h last=%b err=%b want data=%h last=%b err=%b",
                                 beat, a, rd_resp_data, rd_resp_last, rd_resp_err, qd[0], ql[0], qe[0]);
                    end
                    if (!popped_any) begin first_d = rd_resp_data; popped_any = 1; end
                    void'(qd.pop_front()); void'(ql.pop_front()); void'(qe.pop_front());
                    beat++;
                end
            end
        end
        checks++;
        if (qd.size() != 0) begin errors++; $display("FAIL read_timeout: %0d beats missing, want 0", qd.size()); end
        rd_resp_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (rd_resp_valid !== 1'b0 || rd_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL after_burst: valid=%b req_ready=%b want 0 1", rd_resp_valid, rd_req_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (rd_req_ready !== 1'b1 || rd_resp_valid !== 1'b0 || rd_resp_data !== '0 ||
            rd_resp_last !== 1'b0 || rd_resp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: ready=%b valid=%b data=%h last=%b err=%b want 1 0 0 0 0",
                     rd_req_ready, rd_resp_valid, rd_resp_data, rd_resp_last, rd_resp_err);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) do_write(32'(i), $urandom(), 4'hF);
    endtask

    task automatic test_basic();
        int fk;
        logic [DW-1:0] fd;
        do_write(32'h10, 32'hA5, 4'hF);
        do_read(32'h10, '0, 0, fk, fd);
        checks++;
        if (fd !== 32'hA5) begin errors++; $display("FAIL basic_data: got %h want 000000a5", fd); end
        checks++;
        if (fk != 1 + RL) begin errors++; $display("FAIL basic_latency: got %0d want %0d", fk, 1 + RL); end
    endtask

    task automatic test_strobe();
        int fk;
        logic [DW-1:0] fd;
        do_write(32'd4, 32'h11223344, 4'hF);
        do_write(32'd4, 32'hFFFFFFFF, 4'b0101);
        do_read(32'd4, '0, 0, fk, fd);
        checks++;
        if (fd !== 32'h11FF33FF) begin errors++; $display("FAIL strobe: got %h want 11ff33ff", fd); end
    endtask

`ifdef DDR_MEM_ADDR_CHECK_EN
    task automatic test_addr_check();
        int fk;
        logic [DW-1:0] fd;
        do_read(32'(DEPTH + 3), '0, 0, fk, fd);
        do_write(32'd3, 32'h00005A5A, 4'hF);
        do_write(32'(DEPTH + 3), 32'hDEADBEEF, 4'hF);
        do_read(32'd3, '0, 0, fk, fd);
        checks++;
        if (fd !== 32'h00005A5A) begin errors++; $display("FAIL oob_write: got %h want 00005a5a", fd); end
    endtask
`else
    task automatic test_wrap();
        int fk;
        logic [DW-1:0] fd;
        do_read(32'(DEPTH - 2), 4'd7, 0, fk, fd);
        checks++;
        if (fk != 1 + RL) begin errors++; $display("FAIL wrap_latency: got %0d want %0d", fk, 1 + RL); end
    endtask
`endif

    task automatic test_stall();
        int fk;
        logic [DW-1:0] fd;
        do_read(32'($urandom_range(0, DEPTH - 1)), 4'd15, 2, fk, fd);
    endtask

    task automatic test_back_to_back();
        int pops = 0;
        int lasts = 0;
        for (int c = 0; c < 21; c++) begin
            @(posedge clk); #1;
            rd_req_valid = (c < 9);
            rd_req_addr = 32'($urandom_range(0, DEPTH - 1));
            rd_req_len = 4'd1;
            rd_resp_ready = 1'b1;
            @(negedge clk);
            if (c < 9) begin
                checks++;
                if (rd_req_ready !== (c % 3 == 0)) begin
                    errors++;
                    $display("FAIL b2b_ready cycle %0d: got %b want %b", c, rd_req_ready, (c % 3 == 0));
                end
            end
            if (rd_resp_valid === 1'b1) begin pops++; if (rd_resp_last === 1'b1) lasts++; end
        end
        checks++;
        if (pops != 6 || lasts != 3) begin
            errors++;
            $display("FAIL b2b_beats: beats=%0d lasts=%0d want 6 3", pops, lasts);
        end
    endtask

    task automatic test_reset_mid();
        int stray = 0;
        int fk;
        logic [DW-1:0] fd;
        @(posedge clk); #1;
        rd_req_valid = 1'b1; rd_req_addr = '0; rd_req_len = 4'd15; rd_resp_ready = 1'b1;
        @(posedge clk); #1;
        rd_req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (rd_resp_valid !== 1'b0 || rd_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: valid=%b req_ready=%b want 0 1", rd_resp_valid, rd_req_ready);
        end
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (rd_resp_valid !== 1'b0) stray++;
        end
        checks++;
        if (stray != 0) begin errors++; $display("FAIL reset_stray: %0d stray valid cycles, want 0", stray); end
        do_read(32'd7, 4'd3, 0, fk, fd);
    endtask

    task automatic test_random();
        int fk;
        logic [DW-1:0] fd;
        int amax;
`ifdef DDR_MEM_ADDR_CHECK_EN
        amax = DEPTH + 8;
`else
        amax = DEPTH - 1;
`endif
        for (int it = 0; it < 12; it++) begin
            repeat ($urandom_range(0, 3)) do_write(32'($urandom_range(0, amax)), $urandom(), 4'($urandom()));
            do_read(32'($urandom_range(0, amax)), 4'($urandom()), 1, fk, fd);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_basic();
        test_strobe();
`ifdef DDR_MEM_ADDR_CHECK_EN
        test_addr_check();
`else
        test_wrap();
`endif
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
